// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port register file with a per-register busy scoreboard for the
// superscalar MIPS pipeline. The issue stage reads operands and checks busy
// flags, and it marks destination registers busy. Writeback stores results
// and clears the busy flags.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous reset, active-low
//   rd_addr   N_RD read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data   N_RD combinational read data
//   rd_busy   N_RD combinational busy flags of the addressed registers
//   wr_en     N_WR writeback enables
//   wr_addr   N_WR writeback addresses
//   wr_data   N_WR writeback data
//   iss_en    N_WR issue enables; each marks a destination busy
//   iss_addr  N_WR issue destination addresses
//   busy_vec  registered scoreboard, one bit per register
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int N_RD     = 4,
  parameter int N_WR     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  input  logic [N_WR-1:0]          wr_en,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  input  logic [N_WR-1:0]          iss_en,
  input  logic [N_WR*ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  generate
    if (NUM_REGS != 2**ADDR_W) begin : g_bad_num_regs
      $error("regfile_mp_sb: NUM_REGS must equal 2**ADDR_W");
    end
    if (N_RD < 1) begin : g_bad_n_rd
      $error("regfile_mp_sb: N_RD must be at least 1");
    end
    if (N_WR < 1) begin : g_bad_n_wr
      $error("regfile_mp_sb: N_WR must be at least 1");
    end
  endgenerate

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_nxt;

  // Per-register set (issue) and clear (writeback) strobes for this cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (iss_en[i]) set_vec[iss_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      if (wr_en[i])  clr_vec[wr_addr[i*ADDR_W +: ADDR_W]]  = 1'b1;
    end
  end

  // A new producer supersedes the one completing, so set wins over clear.
  always_comb begin
    busy_nxt = set_vec | (busy_q & ~clr_vec);
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Later write ports are younger instructions; the last assignment wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int w = 0; w < N_WR; w++) begin
        if (wr_en[w] &&
            !((ZERO_REG != 0) && (wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
          regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              bsy;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      val = regs[addr];
      bsy = busy_q[addr];
      if (BYPASS != 0) begin
        // Highest-index matching writer is forwarded, same as the store.
        for (int w = 0; w < N_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
            val = wr_data[w*DATA_W +: DATA_W];
          end
        end
        // A completing writeback makes the operand usable now; a
        // same-cycle issue only shows up after the edge.
        if (clr_vec[addr]) bsy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        val = '0;
        bsy = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = val;
    assign rd_busy[p] = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NDIR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic [NWR-1:0]      wr_en, iss_en;
  logic [NWR*AW-1:0]   wr_addr, iss_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic [NR-1:0]       busy_vec, busy_vec_nb;

  regfile_mp_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec));

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_nb));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state plus the rules for reads/updates.
  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];

  function automatic int wa(int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] m_read(int a, bit byp);
    logic [DW-1:0] d;
    if (a == 0) return '0;
    d = m_mem[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wa(w) == a) d = wr_data[w*DW +: DW];
    return d;
  endfunction

  function automatic bit m_rbusy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wa(w) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] m_bvec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Edge update: clears applied first, then sets, so set wins on collision.
  task automatic m_update();
    int a;
    if (!reset) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r] = '0;
        m_busy[r] = 1'b0;
      end
      return;
    end
    for (int w = 0; w < NWR; w++)
      if (wr_en[w]) begin
        a = wa(w);
        if (a != 0) m_mem[a] = wr_data[w*DW +: DW];
        m_busy[a] = 1'b0;
      end
    for (int i = 0; i < NWR; i++)
      if (iss_en[i]) begin
        a = int'(iss_addr[i*AW +: AW]);
        if (a != 0) m_busy[a] = 1'b1;
      end
  endtask

  typedef struct {
    logic         rst_n;
    logic         chk;
    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [63:0]  wdata;
    logic [1:0]   ien;
    logic [9:0]   iaddr;
    logic [19:0]  raddr;
    logic [127:0] exp_d;
    logic [3:0]   exp_b;
    logic [127:0] exp_d_nb;
    logic [3:0]   exp_b_nb;
    logic [31:0]  exp_bv;
  } vec_t;

  vec_t vt [NDIR];

  function automatic vec_t mk(logic rst_n, logic chk, logic [1:0] wen,
      logic [9:0] waddr, logic [63:0] wdata, logic [1:0] ien,
      logic [9:0] iaddr, logic [19:0] raddr, logic [127:0] exp_d,
      logic [3:0] exp_b, logic [127:0] exp_d_nb, logic [3:0] exp_b_nb,
      logic [31:0] exp_bv);
    vec_t v;
    v.rst_n = rst_n; v.chk = chk; v.wen = wen; v.waddr = waddr;
    v.wdata = wdata; v.ien = ien; v.iaddr = iaddr; v.raddr = raddr;
    v.exp_d = exp_d; v.exp_b = exp_b; v.exp_d_nb = exp_d_nb;
    v.exp_b_nb = exp_b_nb; v.exp_bv = exp_bv;
    return v;
  endfunction

  function automatic logic [19:0] r4(logic [4:0] a0, logic [4:0] a1,
                                     logic [4:0] a2, logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] d4(logic [31:0] d0, logic [31:0] d1,
                                      logic [31:0] d2, logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic drive(logic rst_n, logic [1:0] wen, logic [9:0] waddr,
                       logic [63:0] wdata, logic [1:0] ien,
                       logic [9:0] iaddr, logic [19:0] raddr);
    reset = rst_n; wr_en = wen; wr_addr = waddr; wr_data = wdata;
    iss_en = ien; iss_addr = iaddr; rd_addr = raddr;
  endtask

  task automatic check_model_reads(input string tag);
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      check($sformatf("%s rd_data[%0d] bypass", tag, p),
            128'(rd_data[p*DW +: DW]), 128'(m_read(a, 1'b1)));
      check($sformatf("%s rd_data[%0d] nobypass", tag, p),
            128'(rd_data_nb[p*DW +: DW]), 128'(m_read(a, 1'b0)));
      check($sformatf("%s rd_busy[%0d] bypass", tag, p),
            128'(rd_busy[p]), 128'(m_rbusy(a, 1'b1)));
      check($sformatf("%s rd_busy[%0d] nobypass", tag, p),
            128'(rd_busy_nb[p]), 128'(m_rbusy(a, 1'b0)));
    end
  endtask

  initial begin
    logic [31:0] r5 = 32'd5;
    drive(1'b0, 2'b00, '0, '0, 2'b00, '0, '0);
    for (int r = 0; r < NR; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end

    // rst, chk, wen, waddr{a1,a0}, wdata{d1,d0}, ien, iaddr, raddr,
    // exp_d/exp_b (bypass), exp_d_nb/exp_b_nb, exp busy_vec after edge
    vt[0]  = mk(0, 0, 2'b00, '0, '0, 2'b00, '0, r4(0,0,0,0),
                '0, 4'h0, '0, 4'h0, 32'h0);
    vt[1]  = mk(1, 1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b01,
                {5'd0, 5'd5}, r4(5,5,5,5),
                {4{32'hDEADBEEF}}, 4'h0, '0, 4'h0, 32'h0000_0020);
    vt[2]  = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(5,5,5,5),
                {4{32'hDEADBEEF}}, 4'hF, {4{32'hDEADBEEF}}, 4'hF,
                32'h0000_0020);
    vt[3]  = mk(0, 1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h12345678}, 2'b01,
                {5'd0, 5'd6}, r4(5,5,5,5),
                {4{32'h12345678}}, 4'h0, {4{32'hDEADBEEF}}, 4'hF, 32'h0);
    vt[4]  = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(5,5,5,5),
                '0, 4'h0, '0, 4'h0, 32'h0);
    vt[5]  = mk(1, 1, 2'b11, {5'd2, 5'd1}, {32'h22222222, 32'h11111111},
                2'b00, '0, r4(0,0,0,0), '0, 4'h0, '0, 4'h0, 32'h0);
    vt[6]  = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(1,2,1,0),
                d4(32'h11111111, 32'h22222222, 32'h11111111, 32'h0), 4'h0,
                d4(32'h11111111, 32'h22222222, 32'h11111111, 32'h0), 4'h0,
                32'h0);
    vt[7]  = mk(1, 1, 2'b11, {5'd7, 5'd7}, {32'hB, 32'hA}, 2'b00, '0,
                r4(7,7,7,7), {4{32'hB}}, 4'h0, '0, 4'h0, 32'h0);
    vt[8]  = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(7,7,7,7),
                {4{32'hB}}, 4'h0, {4{32'hB}}, 4'h0, 32'h0);
    vt[9]  = mk(1, 1, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 2'b01,
                {5'd0, 5'd0}, r4(0,0,0,0), '0, 4'h0, '0, 4'h0, 32'h0);
    vt[10] = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(0,0,0,0),
                '0, 4'h0, '0, 4'h0, 32'h0);
    vt[11] = mk(1, 1, 2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, r4(9,9,9,9),
                '0, 4'h0, '0, 4'h0, 32'h0000_0200);
    vt[12] = mk(1, 1, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h99999999}, 2'b00,
                '0, r4(9,9,9,9), {4{32'h99999999}}, 4'h0, '0, 4'hF, 32'h0);
    vt[13] = mk(1, 1, 2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, r4(9,9,9,9),
                {4{32'h99999999}}, 4'h0, {4{32'h99999999}}, 4'h0,
                32'h0000_0200);
    vt[14] = mk(1, 1, 2'b01, {5'd0, 5'd9}, {32'h0, 32'hCAFEF00D}, 2'b10,
                {5'd9, 5'd0}, r4(9,9,9,9), {4{32'hCAFEF00D}}, 4'h0,
                {4{32'h99999999}}, 4'hF, 32'h0000_0200);
    vt[15] = mk(1, 1, 2'b00, '0, '0, 2'b00, '0, r4(9,7,1,2),
                d4(32'hCAFEF00D, 32'hB, 32'h11111111, 32'h22222222), 4'h1,
                d4(32'hCAFEF00D, 32'hB, 32'h11111111, 32'h22222222), 4'h1,
                32'h0000_0200);

    @(negedge clk);
    for (int i = 0; i < NDIR; i++) begin
      drive(vt[i].rst_n, vt[i].wen, vt[i].waddr, vt[i].wdata, vt[i].ien,
            vt[i].iaddr, vt[i].raddr);
      #1;
      if (vt[i].chk) begin
        check($sformatf("dir%0d rd_data bypass", i), rd_data, vt[i].exp_d);
        check($sformatf("dir%0d rd_busy bypass", i), 128'(rd_busy),
              128'(vt[i].exp_b));
        check($sformatf("dir%0d rd_data nobypass", i), rd_data_nb,
              vt[i].exp_d_nb);
        check($sformatf("dir%0d rd_busy nobypass", i), 128'(rd_busy_nb),
              128'(vt[i].exp_b_nb));
      end
      @(posedge clk);
      m_update();
      #1;
      check($sformatf("dir%0d busy_vec bypass", i), 128'(busy_vec),
            128'(vt[i].exp_bv));
      check($sformatf("dir%0d busy_vec nobypass", i), 128'(busy_vec_nb),
            128'(vt[i].exp_bv));
      @(negedge clk);
    end

    // Randomized traffic; addresses biased toward a few registers so that
    // port collisions and set/clear overlaps happen often.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      wr_en = 2'($urandom_range(0, 3));
      iss_en = 2'($urandom_range(0, 3));
      for (int w = 0; w < NWR; w++) begin
        wr_addr[w*AW +: AW]  = ($urandom_range(0, 1) != 0) ?
                               5'($urandom_range(0, 7)) : 5'($urandom);
        iss_addr[w*AW +: AW] = ($urandom_range(0, 1) != 0) ?
                               5'($urandom_range(0, 7)) : 5'($urandom);
        wr_data[w*DW +: DW]  = $urandom;
      end
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ?
                              5'($urandom_range(0, 7)) : 5'($urandom);
      #1;
      check_model_reads("rand");
      @(posedge clk);
      m_update();
      #1;
      check("rand busy_vec bypass", 128'(busy_vec), 128'(m_bvec()));
      check("rand busy_vec nobypass", 128'(busy_vec_nb), 128'(m_bvec()));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
